// File: rtl/sys2d_pkg.sv
// Shared types and helpers for the SYS2D accumulator drain path.
package sys2d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_e;

    // Zero any word whose sign bit is set; width is the live accumulator width (<= 64).
    function automatic logic [63:0] relu_word(input logic [63:0] word, input int unsigned width);
        return word[6'(width - 1)] ? 64'd0 : word;
    endfunction

endpackage

// File: rtl/acc_row_fifo.sv
// Aligned-row FIFO: registered storage, combinational head read, separate occupancy count,
// almost-full flag and sticky overflow on a dropped write.
module acc_row_fifo #(
    parameter int ROW_WIDTH  = 512,
    parameter int DEPTH      = 32,
    parameter int AFULL_FREE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ROW_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    output logic [ROW_WIDTH-1:0] rd_data,
    output logic                 valid,
    output logic                 pop,
    output logic                 afull,
    input  logic                 ovf_clr,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ROW_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;
    logic                 w_full;
    logic                 w_do_wr;

    assign valid   = (r_count != '0);
    assign pop     = rd_en & valid;
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a write against a full FIFO still lands.
    assign w_do_wr = wr_en & (~w_full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_wr, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en & w_full & ~pop) r_overflow <= 1'b1;
            else if (ovf_clr)          r_overflow <= 1'b0;
        end
    end

    assign rd_data  = r_mem[r_rptr];
    assign afull    = ((CNT_W'(DEPTH) - r_count) <= CNT_W'(AFULL_FREE));
    assign overflow = r_overflow;

endmodule

// File: rtl/data_shift_reg.sv
// Enabled shift register of ARRAY_DEPTH stages (>= 1); all stages hold while en is low.
module data_shift_reg #(
    parameter int DATA_WIDTH  = 32,
    parameter int ARRAY_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] r_stage [ARRAY_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARRAY_DEPTH; i++) r_stage[i] <= '0;
        end else if (en) begin
            r_stage[0] <= d;
            for (int i = 1; i < ARRAY_DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign q = r_stage[ARRAY_DEPTH-1];

endmodule

// File: rtl/sys2d_acc_deskew_drain.sv
// Re-aligns skewed SYS2D accumulator columns, buffers rows and tracks tile completion.
// Optional ReLU at FIFO write: define ACC_DRAIN_RELU_EN.
//
//   state | meaning
//   IDLE  | waiting for start; pops do not count
//   RUN   | counting popped rows down to zero
//   DONE  | done pulse for one cycle, then IDLE
module sys2d_acc_deskew_drain
    import sys2d_pkg::*;
#(
    parameter int SYS_ARRAY_WIDTH = 16,
    parameter int ACC_WIDTH       = 32,
    parameter int FIFO_DEPTH      = 32,
    parameter int ROW_CNT_WIDTH   = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      sys2d_en,
    input  logic                                      acc_valid_in,
    input  logic [SYS_ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] acc_data_in,
    input  logic                                      start,
    input  logic [ROW_CNT_WIDTH-1:0]                  cfg_num_rows,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [SYS_ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] out_data,
    output logic                                      fifo_afull,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overflow_err
);

    localparam int W = SYS_ARRAY_WIDTH;

    logic [W-1:0][ACC_WIDTH-1:0] w_row_aligned;
    logic [W-1:0][ACC_WIDTH-1:0] w_row_wr;
    logic                        w_valid_out;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_start_ok;

    drain_state_e             r_state;
    logic [ROW_CNT_WIDTH-1:0] r_rows_left;
    logic                     r_busy;
    logic                     r_done;

    // Column j trails column 0 by j cycles, so it needs W-1-j stages to line up with column W-1.
    for (genvar j = 0; j < W; j++) begin : g_col
        if (j < W - 1) begin : g_dly
            data_shift_reg #(
                .DATA_WIDTH  (ACC_WIDTH),
                .ARRAY_DEPTH (W - 1 - j)
            ) u_col_dly (
                .clk   (clk),
                .reset (reset),
                .en    (sys2d_en),
                .d     (acc_data_in[j]),
                .q     (w_row_aligned[j])
            );
        end else begin : g_thru
            assign w_row_aligned[j] = acc_data_in[j];
        end
`ifdef ACC_DRAIN_RELU_EN
        assign w_row_wr[j] = ACC_WIDTH'(relu_word(64'(w_row_aligned[j]), ACC_WIDTH));
`else
        assign w_row_wr[j] = w_row_aligned[j];
`endif
    end

    data_shift_reg #(
        .DATA_WIDTH  (1),
        .ARRAY_DEPTH (W - 1)
    ) u_valid_pipe (
        .clk   (clk),
        .reset (reset),
        .en    (sys2d_en),
        .d     (acc_valid_in),
        .q     (w_valid_out)
    );

    assign w_push     = sys2d_en & w_valid_out;
    assign w_start_ok = (r_state == IDLE) & start;

    acc_row_fifo #(
        .ROW_WIDTH  (W * ACC_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AFULL_FREE (W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_push),
        .wr_data  (w_row_wr),
        .rd_en    (out_ready),
        .rd_data  (out_data),
        .valid    (out_valid),
        .pop      (w_pop),
        .afull    (fifo_afull),
        .ovf_clr  (w_start_ok),
        .overflow (overflow_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rows_left <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_rows_left <= cfg_num_rows;
                        if (cfg_num_rows == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_pop) begin
                        r_rows_left <= r_rows_left - ROW_CNT_WIDTH'(1);
                        if (r_rows_left == ROW_CNT_WIDTH'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_sys2d_acc_deskew_drain.sv
// Bench for sys2d_acc_deskew_drain (W=4, ACC=32, DEPTH=8) against a row-level queue model.
module tb_sys2d_acc_deskew_drain;

    localparam int W  = 4;
    localparam int AW = 32;
    localparam int D  = 8;
    localparam int RW = 16;
    localparam int NK = 4096;

    typedef logic [W-1:0][AW-1:0] row_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          sys2d_en;
    logic          acc_valid_in;
    row_t          acc_data_in;
    logic          start;
    logic [RW-1:0] cfg_num_rows;
    logic          out_valid;
    logic          out_ready;
    row_t          out_data;
    logic          fifo_afull;
    logic          busy;
    logic          done;
    logic          overflow_err;

    always #5 clk = ~clk;

    sys2d_acc_deskew_drain #(
        .SYS_ARRAY_WIDTH (W),
        .ACC_WIDTH       (AW),
        .FIFO_DEPTH      (D),
        .ROW_CNT_WIDTH   (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sys2d_en     (sys2d_en),
        .acc_valid_in (acc_valid_in),
        .acc_data_in  (acc_data_in),
        .start        (start),
        .cfg_num_rows (cfg_num_rows),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .fifo_afull   (fifo_afull),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Rows indexed by array cycle k: row k's column j is presented at array cycle k+j.
    logic [AW-1:0] row_data [NK][W];
    bit            row_valid [NK];
    int            ac = 0;
    int            decided = 0;
    int            cyc = 0;

    row_t mq[$];
    bit   m_ovf = 0, m_busy = 0, m_done = 0;
    int   m_rows_left = 0;

    int   en_mode = 1, rdy_mode = 1, val_mode = 0;
    int   dir_left = 0, dir_r = 0;
    bit   data_dir = 0;
    int   done_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic row_t relu_row(input row_t r);
        row_t o = r;
`ifdef ACC_DRAIN_RELU_EN
        for (int j = 0; j < W; j++) if (o[j][AW-1]) o[j] = '0;
`endif
        return o;
    endfunction

    task automatic decide_row(input int k);
        row_valid[k] = 1'b0;
        for (int j = 0; j < W; j++) row_data[k][j] = $urandom;
        if (val_mode == 1) begin
            row_valid[k] = ($urandom_range(0, 1) == 1);
        end else if (val_mode == 2 && dir_left > 0) begin
            row_valid[k] = 1'b1;
            if (data_dir)
                for (int j = 0; j < W; j++) row_data[k][j] = 32'(32'h100 * dir_r + j);
            dir_r++;
            dir_left--;
        end
    endtask

    task automatic step(input bit st = 1'b0, input int cfg = 0);
        bit   push, pop, full_pre, nb, nd;
        row_t pr;
        if (ac >= NK - 1) begin
            $display("FAIL row_table_exhausted got=%0d exp<%0d", ac, NK - 1);
            $fatal(1);
        end
        while (decided <= ac) begin
            decide_row(decided);
            decided++;
        end
        acc_valid_in = row_valid[ac];
        for (int j = 0; j < W; j++) acc_data_in[j] = (ac - j >= 0) ? row_data[ac-j][j] : '0;
        case (en_mode)
            0:       sys2d_en = 1'b0;
            2:       sys2d_en = (cyc % 2 == 0);
            3:       sys2d_en = ($urandom_range(0, 3) != 0);
            default: sys2d_en = 1'b1;
        endcase
        push = 1'b0;
        pr   = '0;
        if (sys2d_en && ac >= W - 1) begin
            if (row_valid[ac-W+1]) begin
                push = 1'b1;
                for (int j = 0; j < W; j++) pr[j] = row_data[ac-W+1][j];
            end
        end
        case (rdy_mode)
            0:       out_ready = 1'b0;
            2:       out_ready = ($urandom_range(0, 1) == 1);
            3:       out_ready = push && (mq.size() == D);
            default: out_ready = 1'b1;
        endcase
        start        = st;
        cfg_num_rows = RW'(cfg);
        pop      = out_ready && (mq.size() != 0);
        full_pre = (mq.size() == D);

        @(posedge clk);
        #1;

        nb = m_busy;
        nd = 1'b0;
        if (m_done) begin
            nd = 1'b0;
        end else if (!m_busy) begin
            if (st) begin
                m_ovf = 1'b0;
                if (cfg == 0) nd = 1'b1;
                else begin
                    nb          = 1'b1;
                    m_rows_left = cfg;
                end
            end
        end else if (pop) begin
            m_rows_left--;
            if (m_rows_left == 0) begin
                nb = 1'b0;
                nd = 1'b1;
            end
        end
        m_busy = nb;
        m_done = nd;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (!full_pre || pop) mq.push_back(relu_row(pr));
            else m_ovf = 1'b1;
        end
        if (sys2d_en) ac++;
        cyc++;
        if (done) done_cnt++;

        chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", 128'(out_data), 128'(mq[0]));
        chk("fifo_afull", 128'(fifo_afull), 128'((D - mq.size()) <= W));
        chk("overflow_err", 128'(overflow_err), 128'(m_ovf));
        chk("busy", 128'(busy), 128'(m_busy));
        chk("done", 128'(done), 128'(m_done));
    endtask

    task automatic drain(input int n);
        val_mode = 0;
        en_mode  = 1;
        rdy_mode = 1;
        repeat (n) step();
    endtask

    initial begin
        int first;
        reset        = 1'b0;
        sys2d_en     = 1'b0;
        acc_valid_in = 1'b0;
        acc_data_in  = '0;
        start        = 1'b0;
        cfg_num_rows = '0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_afull", 128'(fifo_afull), 128'(0));
        chk("rst_ovf", 128'(overflow_err), 128'(0));
        chk("rst_busy_done", 128'({busy, done}), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        // Directed rows 0x000.., 0x100.., 0x200.. with first out_valid at cycle W
        en_mode = 1; rdy_mode = 1; val_mode = 2; data_dir = 1; dir_left = 3; dir_r = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (first < 0 && out_valid) first = i + 1;
        end
        chk("t1_first_valid_cycle", 128'(first), 128'(W));

        // Same rows under a 1010 enable pattern
        val_mode = 2; dir_left = 3; dir_r = 0; en_mode = 2;
        repeat (24) step();
        drain(8);

        // Fill to full, then write and pop in the same cycle
        data_dir = 0; rdy_mode = 0; val_mode = 2; dir_left = 8;
        repeat (8 + W + 2) step();
        chk("t4_full_afull", 128'(fifo_afull), 128'(1));
        dir_left = 1; rdy_mode = 3;
        repeat (W + 2) step();
        chk("t4_no_ovf", 128'(overflow_err), 128'(0));
        drain(12);

        // Nine rows into a closed FIFO: ninth dropped
        rdy_mode = 0; val_mode = 2; data_dir = 1; dir_left = 9; dir_r = 0;
        repeat (9 + W + 2) step();
        chk("t3_ovf_set", 128'(overflow_err), 128'(1));
        drain(12);

        // Tile of 3 rows, then zero-row tile
        val_mode = 0; rdy_mode = 1;
        step(1'b1, 3);
        chk("t5_busy", 128'(busy), 128'(1));
        chk("t5_ovf_cleared", 128'(overflow_err), 128'(0));
        done_cnt = 0;
        val_mode = 2; dir_left = 3;
        repeat (12) step();
        chk("t5_done_pulses", 128'(done_cnt), 128'(1));
        chk("t5_busy_end", 128'(busy), 128'(0));
        step(1'b1, 0);
        chk("t5_zero_done", 128'(done), 128'(1));
        step();
        chk("t5_zero_done_end", 128'(done), 128'(0));

        // Randomized traffic with random tile starts
        en_mode = 3; rdy_mode = 2; val_mode = 1; data_dir = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) step(1'b1, $urandom_range(0, 5));
            else step();
        end
        drain(20);
        repeat (4) step();

        // Reset with 3 rows in the FIFO and 2 still in the deskew pipe
        rdy_mode = 0; en_mode = 1; val_mode = 2; dir_left = 5;
        repeat (6) step();
        reset = 1'b0;
        #1;
        chk("t6_out_valid_async", 128'(out_valid), 128'(0));
        chk("t6_afull_async", 128'(fifo_afull), 128'(0));
        mq.delete();
        m_ovf = 0; m_busy = 0; m_done = 0; m_rows_left = 0;
        for (int k = 0; k < decided; k++) row_valid[k] = 1'b0;
        dir_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drain(10);
        val_mode = 2; dir_left = 2;
        repeat (10) step();

`ifdef ACC_DRAIN_RELU_EN
        // Directed ReLU row: negatives and -0 map to +0
        val_mode = 0;
        repeat (W) step();
        decided = ac + 1;
        row_valid[ac] = 1'b1;
        row_data[ac][0] = 32'hFFFF_FFFF;
        row_data[ac][1] = 32'h8000_0000;
        row_data[ac][2] = 32'h3F80_0000;
        row_data[ac][3] = 32'h7FFF_FFFF;
        rdy_mode = 0;
        for (int k = 1; k < W; k++) begin
            row_valid[ac+k] = 1'b0;
            for (int j = 0; j < W; j++) row_data[ac+k][j] = '0;
        end
        decided = ac + W;
        repeat (W + 1) step();
        chk("relu_row", 128'(out_data), {32'h7FFF_FFFF, 32'h3F80_0000, 32'h0, 32'h0});
        drain(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
